// File: rtl/xadc_pkg.sv
// xadc_pkg: shared FSM type, DRP register addresses and default timeout for the XADC DRP arbiter
package xadc_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  localparam logic [6:0] ADDR_AUX0 = 7'h10;
  localparam logic [6:0] ADDR_AUX1 = 7'h11;
  localparam logic [6:0] ADDR_AUX2 = 7'h12;
  localparam logic [6:0] ADDR_AUX3 = 7'h13;
  localparam logic [6:0] ADDR_CFG0 = 7'h40;
  localparam logic [6:0] ADDR_CFG1 = 7'h41;
  localparam logic [6:0] ADDR_CFG2 = 7'h42;
  localparam logic [6:0] ADDR_SEQ0 = 7'h48;
  localparam logic [6:0] ADDR_SEQ1 = 7'h49;
  localparam int unsigned DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin one-hot grant favouring the port not granted last
module rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);
  always_comb grant = !enable ? 2'b00 : (&eligible) ? (last_grant ? 2'b01 : 2'b10) : eligible;
endmodule

// File: rtl/xadc_drp_arbiter.sv
// xadc_drp_arbiter: round-robin sharing of the XADC DRP between two requesters with DRDY timeout
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [6:0]  req0_addr,
  input  logic        req0_we,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [6:0]  req1_addr,
  input  logic        req1_we,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic [15:0] rdata,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic [15:0] DI,
  output logic        DWE,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        BUSY
);
  localparam logic [15:0] tmo = 16'(TIMEOUT_CYCLES);
  state_t      state, state_n;
  logic        last_grant, owner, accept, win, hit, expire;
  logic [1:0]  elig, grant;
  logic [15:0] cnt;
  assign elig = {req1_valid && (!req1_we || !BUSY), req0_valid && (!req0_we || !BUSY)};
  rr_arbiter2 u_arb (
    .eligible   (elig),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .grant      (grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  always_comb begin
    accept  = |grant;
    win     = grant[1];
    hit     = state == WAIT && DRDY;
    expire  = state == WAIT && !DRDY && cnt == tmo;
    state_n = accept ? WAIT : (hit || expire) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      DEN        <= 1'b0;
      DWE        <= 1'b0;
      DADDR      <= '0;
      DI         <= '0;
      rdata      <= '0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
    end else begin
      DEN       <= accept;
      DADDR     <= accept ? (win ? req1_addr : req0_addr) : '0;
      DI        <= accept ? (win ? req1_wdata : req0_wdata) : '0;
      DWE       <= accept && (win ? req1_we : req0_we);
      cnt       <= accept ? '0 : state == WAIT ? cnt + 16'd1 : cnt;
      owner     <= accept ? win : owner;
      last_grant <= accept ? win : last_grant;
      rdata     <= hit ? DO : expire ? '0 : rdata;
      req0_done <= (hit || expire) && !owner;
      req1_done <= (hit || expire) && owner;
      req0_err  <= expire && !owner;
      req1_err  <= expire && owner;
    end
endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// tb_xadc_drp_arbiter: scenario and randomized checks of the DRP arbiter against a behavioural model
module tb_xadc_drp_arbiter;
  import xadc_pkg::*;
  localparam int T = 8;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_we = 0, req1_we = 0;
  logic [6:0] req0_addr = 0, req1_addr = 0;
  logic [15:0] req0_wdata = 0, req1_wdata = 0;
  logic req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err;
  logic [15:0] rdata, DI;
  logic [15:0] DO = 0;
  logic [6:0] DADDR;
  logic DEN, DWE;
  logic DRDY = 0, BUSY = 0;
  int n_chk = 0, n_pass = 0;
  int resp_lat = 0, resp_cnt = 0;
  logic [15:0] resp_do = 0;
  logic inject = 0;
  bit m_last = 1;

  xadc_drp_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
    .rdata(rdata), .DADDR(DADDR), .DEN(DEN), .DI(DI), .DWE(DWE),
    .DO(DO), .DRDY(DRDY), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  // XADC stand-in: answers resp_lat cycles after DEN (0 = never), plus manual DRDY injection
  always @(negedge clk) begin
    DRDY = inject;
    DO = 16'($urandom);
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        DRDY = 1;
        DO = resp_do;
      end
    end
    if (DEN === 1'b1 && resp_lat > 0) resp_cnt = resp_lat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output logic [1:0] g, output bit ok);
    ok = 0;
    g = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      g = {req1_ready, req0_ready};
      tick();
      if (g != 2'b00) ok = 1;
    end
  endtask

  task automatic wait_done(input int lim, output int n, output logic [1:0] d, output logic [1:0] e,
                           output logic [15:0] rd, output int dens, output bit ok);
    ok = 0; n = 0; dens = 0; d = 0; e = 0; rd = 0;
    while (!ok && n < lim) begin
      tick();
      n++;
      if (DEN === 1'b1) dens++;
      if (req0_done || req1_done) begin
        ok = 1;
        d = {req1_done, req0_done};
        e = {req1_err, req0_err};
        rd = rdata;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    n_chk++;
    if ({DEN, DWE, DADDR, DI, rdata, req0_done, req1_done, req0_err, req1_err} !== '0)
      $display("FAIL reset_outputs: got DEN=%b DWE=%b DADDR=%h DI=%h rdata=%h want all 0", DEN, DWE, DADDR, DI, rdata);
    else n_pass++;
    rst = 0;
    tick();
    n_chk++;
    if ({DEN, DWE, DADDR, DI, rdata, req0_done, req1_done, req0_err, req1_err} !== '0)
      $display("FAIL post_reset_outputs: got DEN=%b DADDR=%h DI=%h rdata=%h want all 0", DEN, DADDR, DI, rdata);
    else n_pass++;
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL idle_ready: got %b want 00", {req1_ready, req0_ready});
    else n_pass++;
    req0_valid = 1;
    req1_valid = 1;
    #1;
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL first_contest: got %b want 01", {req1_ready, req0_ready});
    else n_pass++;
    req0_valid = 0;
    req1_valid = 0;
    m_last = 1;
  endtask

  task automatic test_contention();
    logic [1:0] g, d, e;
    logic [15:0] rd;
    int n, dens;
    bit ok, w;
    logic [6:0] na0 = 7'h20, na1 = 7'h30;
    req0_we = 0; req1_we = 0;
    req0_addr = na0; req1_addr = na1;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      w = !m_last;
      resp_lat = $urandom_range(1, 3);
      resp_do = 16'($urandom);
      wait_accept(g, ok);
      n_chk++;
      if (!ok || g !== (w ? 2'b10 : 2'b01)) $display("FAIL contention_grant%0d: got %b want %b", i, g, w ? 2'b10 : 2'b01);
      else n_pass++;
      n_chk++;
      if (DEN !== 1'b1 || DADDR !== (w ? na1 : na0)) $display("FAIL contention_cmd%0d: got DEN=%b DADDR=%h want 1 %h", i, DEN, DADDR, w ? na1 : na0);
      else n_pass++;
      m_last = w;
      if (w) begin na1++; req1_addr = na1; end
      else begin na0++; req0_addr = na0; end
      wait_done(20, n, d, e, rd, dens, ok);
      n_chk++;
      if (!ok || d !== (w ? 2'b10 : 2'b01) || e !== 2'b00 || rd !== resp_do || n != resp_lat + 1)
        $display("FAIL contention_done%0d: got done=%b err=%b rdata=%h lat=%0d want %b 00 %h %0d", i, d, e, rd, n, w ? 2'b10 : 2'b01, resp_do, resp_lat + 1);
      else n_pass++;
    end
    req0_valid = 0;
    req1_valid = 0;
    tick();
  endtask

  task automatic test_single_read();
    logic [1:0] g, d, e;
    logic [15:0] rd;
    int n, dens;
    bit ok;
    resp_lat = 2;
    resp_do = 16'hABC0;
    req0_addr = ADDR_AUX0; req0_we = 0; req0_valid = 1;
    wait_accept(g, ok);
    n_chk++;
    if (!ok || g !== 2'b01) $display("FAIL single_grant: got %b want 01", g);
    else n_pass++;
    n_chk++;
    if (DEN !== 1'b1 || DADDR !== 7'h10 || DWE !== 1'b0) $display("FAIL single_cmd: got DEN=%b DADDR=%h DWE=%b want 1 10 0", DEN, DADDR, DWE);
    else n_pass++;
    req0_valid = 0;
    m_last = 0;
    wait_done(20, n, d, e, rd, dens, ok);
    n_chk++;
    if (!ok || d !== 2'b01 || e !== 2'b00 || rd !== 16'hABC0 || n != 3 || dens != 0)
      $display("FAIL single_done: got done=%b err=%b rdata=%h lat=%0d extra_den=%0d want 01 00 abc0 3 0", d, e, rd, n, dens);
    else n_pass++;
    tick();
    n_chk++;
    if ({req1_done, req0_done} !== 2'b00) $display("FAIL single_pulse: got %b want 00", {req1_done, req0_done});
    else n_pass++;
  endtask

  task automatic test_busy_write();
    logic [1:0] g, d, e;
    logic [15:0] rd;
    int n, dens;
    bit ok, seen;
    BUSY = 1;
    req1_addr = ADDR_CFG1; req1_we = 1; req1_wdata = 16'h2000; req1_valid = 1;
    req0_addr = ADDR_AUX1; req0_we = 0; req0_valid = 1;
    resp_lat = 1;
    resp_do = 16'h1234;
    wait_accept(g, ok);
    n_chk++;
    if (!ok || g !== 2'b01 || DWE !== 1'b0 || DADDR !== ADDR_AUX1) $display("FAIL busy_read_first: got g=%b DWE=%b DADDR=%h want 01 0 11", g, DWE, DADDR);
    else n_pass++;
    req0_valid = 0;
    m_last = 0;
    wait_done(20, n, d, e, rd, dens, ok);
    n_chk++;
    if (!ok || d !== 2'b01 || rd !== 16'h1234) $display("FAIL busy_read_done: got done=%b rdata=%h want 01 1234", d, rd);
    else n_pass++;
    seen = 0;
    repeat (5) begin
      #1;
      seen |= req1_ready | DEN;
      tick();
    end
    n_chk++;
    if (seen) $display("FAIL busy_gate: got write issued=1 want 0");
    else n_pass++;
    BUSY = 0;
    wait_accept(g, ok);
    n_chk++;
    if (!ok || g !== 2'b10 || {DEN, DWE, DADDR, DI} !== {1'b1, 1'b1, 7'h41, 16'h2000})
      $display("FAIL busy_write_cmd: got g=%b DEN=%b DWE=%b DADDR=%h DI=%h want 10 1 1 41 2000", g, DEN, DWE, DADDR, DI);
    else n_pass++;
    req1_valid = 0;
    m_last = 1;
    wait_done(20, n, d, e, rd, dens, ok);
    n_chk++;
    if (!ok || d !== 2'b10 || e !== 2'b00) $display("FAIL busy_write_done: got done=%b err=%b want 10 00", d, e);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    logic [1:0] g, d, e;
    logic [15:0] rd;
    int n, dens;
    bit ok, seen;
    resp_lat = 0;
    req0_addr = ADDR_AUX2; req0_we = 0; req0_valid = 1;
    wait_accept(g, ok);
    req0_valid = 0;
    m_last = 0;
    wait_done(40, n, d, e, rd, dens, ok);
    n_chk++;
    if (!ok || d !== 2'b01 || e !== 2'b01 || rd !== 16'h0000 || n != T + 1)
      $display("FAIL timeout_done: got done=%b err=%b rdata=%h lat=%0d want 01 01 0000 %0d", d, e, rd, n, T + 1);
    else n_pass++;
    inject = 1;
    tick();
    inject = 0;
    seen = 0;
    repeat (4) begin
      tick();
      seen |= req0_done | req1_done;
    end
    n_chk++;
    if (seen) $display("FAIL late_drdy: got done=1 want 0");
    else n_pass++;
    resp_lat = 1;
    resp_do = 16'h5A5A;
    req0_addr = ADDR_AUX3; req0_valid = 1;
    wait_accept(g, ok);
    req0_valid = 0;
    wait_done(20, n, d, e, rd, dens, ok);
    n_chk++;
    if (!ok || d !== 2'b01 || e !== 2'b00 || rd !== 16'h5A5A || n != 2)
      $display("FAIL after_timeout: got done=%b err=%b rdata=%h lat=%0d want 01 00 5a5a 2", d, e, rd, n);
    else n_pass++;
    tick();
  endtask

  task automatic test_stray_drdy();
    logic [1:0] g, d, e;
    logic [15:0] rd;
    int n, dens;
    bit ok, seen;
    inject = 1;
    tick();
    inject = 0;
    seen = 0;
    repeat (3) begin
      tick();
      seen |= req0_done | req1_done | DEN;
    end
    n_chk++;
    if (seen) $display("FAIL stray_drdy: got activity=1 want 0");
    else n_pass++;
    resp_lat = 1;
    resp_do = 16'hBEEF;
    req0_addr = ADDR_CFG0; req0_we = 0; req0_valid = 1;
    req1_addr = ADDR_CFG2; req1_we = 0; req1_valid = 1;
    wait_accept(g, ok);
    req0_valid = 0;
    req1_valid = 0;
    n_chk++;
    if (!ok || g !== (m_last ? 2'b01 : 2'b10)) $display("FAIL stray_state: got %b want %b", g, m_last ? 2'b01 : 2'b10);
    else n_pass++;
    m_last = !m_last;
    wait_done(20, n, d, e, rd, dens, ok);
    n_chk++;
    if (!ok || d !== g || rd !== 16'hBEEF) $display("FAIL stray_txn: got done=%b rdata=%h want %b beef", d, rd, g);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [1:0] g, d, e;
    logic [15:0] rd;
    int n, dens;
    bit ok, seen;
    resp_lat = 0;
    req1_addr = ADDR_SEQ0; req1_we = 0; req1_valid = 1;
    wait_accept(g, ok);
    req1_valid = 0;
    tick();
    tick();
    rst = 1;
    #1;
    n_chk++;
    if ({DEN, DWE, DADDR, DI, rdata, req0_done, req1_done, req0_err, req1_err} !== '0)
      $display("FAIL reset_mid_outputs: got DEN=%b DADDR=%h DI=%h rdata=%h want all 0", DEN, DADDR, DI, rdata);
    else n_pass++;
    tick();
    tick();
    rst = 0;
    m_last = 1;
    seen = 0;
    repeat (T + 4) begin
      tick();
      seen |= req0_done | req1_done | DEN;
    end
    n_chk++;
    if (seen) $display("FAIL reset_mid_drop: got activity=1 want 0");
    else n_pass++;
    req0_addr = ADDR_SEQ1; req0_we = 0; req0_valid = 1;
    req1_valid = 1;
    #1;
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL reset_mid_rr: got %b want 01", {req1_ready, req0_ready});
    else n_pass++;
    resp_lat = 1;
    resp_do = 16'h0F0F;
    wait_accept(g, ok);
    req0_valid = 0;
    req1_valid = 0;
    m_last = 0;
    wait_done(20, n, d, e, rd, dens, ok);
    n_chk++;
    if (!ok || d !== 2'b01 || rd !== 16'h0F0F) $display("FAIL reset_mid_next: got done=%b rdata=%h want 01 0f0f", d, rd);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] g, d, e, exp_g;
    logic [15:0] rd, exp_rd, wd0, wd1;
    logic [6:0] a0, a1;
    int n, dens, lat;
    bit ok, v0, v1, we0, we1, e0, e1, w, seen;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1;
      we0 = $urandom_range(0, 2) == 0;
      we1 = $urandom_range(0, 2) == 0;
      a0 = 7'($urandom); a1 = 7'($urandom);
      wd0 = 16'($urandom); wd1 = 16'($urandom);
      BUSY = $urandom_range(0, 3) == 0;
      lat = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 4);
      resp_lat = lat;
      resp_do = 16'($urandom);
      req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = wd0;
      req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = wd1;
      e0 = v0 && (!we0 || !BUSY);
      e1 = v1 && (!we1 || !BUSY);
      if (!e0 && !e1) begin
        seen = 0;
        repeat (2) begin
          #1;
          seen |= req0_ready | req1_ready;
          tick();
        end
        n_chk++;
        if (seen) $display("FAIL rand_blocked%0d: got ready=1 want 0", i);
        else n_pass++;
        BUSY = 0;
        e0 = v0;
        e1 = v1;
      end
      w = (e0 && e1) ? !m_last : e1;
      exp_g = w ? 2'b10 : 2'b01;
      wait_accept(g, ok);
      n_chk++;
      if (!ok || g !== exp_g || DEN !== 1'b1 || DADDR !== (w ? a1 : a0) || DWE !== (w ? we1 : we0) || DI !== (w ? wd1 : wd0))
        $display("FAIL rand_cmd%0d: got g=%b DEN=%b DADDR=%h DWE=%b DI=%h want %b 1 %h %b %h", i, g, DEN, DADDR, DWE, DI, exp_g, w ? a1 : a0, w ? we1 : we0, w ? wd1 : wd0);
      else n_pass++;
      req0_valid = 0;
      req1_valid = 0;
      m_last = w;
      exp_rd = lat > 0 ? resp_do : 16'h0000;
      wait_done(40, n, d, e, rd, dens, ok);
      n_chk++;
      if (!ok || d !== exp_g || e !== (lat > 0 ? 2'b00 : exp_g) || n != (lat > 0 ? lat + 1 : T + 1) || dens != 0 ||
          ((lat == 0 || !(w ? we1 : we0)) && rd !== exp_rd))
        $display("FAIL rand_done%0d: got done=%b err=%b rdata=%h lat=%0d extra_den=%0d want %b %b %h %0d 0", i, d, e, rd, n, dens, exp_g, lat > 0 ? 2'b00 : exp_g, exp_rd, lat > 0 ? lat + 1 : T + 1);
      else n_pass++;
      tick();
      n_chk++;
      if ({req1_done, req0_done, req1_err, req0_err} !== 4'b0) $display("FAIL rand_pulse%0d: got %b want 0000", i, {req1_done, req0_done, req1_err, req0_err});
      else n_pass++;
    end
    BUSY = 0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_busy_write();
    test_timeout();
    test_stray_drdy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
